// File: rtl/pixel_binner.sv
// -----------------------------------------------------------------------------
// pixel_binner
//
// Bins an IN_ROWS x IN_COLS raster frame, arriving one pixel per handshake with
// its row/column coordinates, down to OUT_ROWS x OUT_COLS. Each output pixel is
// the average of one BIN_Y x BIN_X input block. Horizontal partial sums are
// built in a single accumulator and vertical partial sums are parked in a line
// buffer of OUT_COLS entries until the last row of the bin arrives.
//
// Optional feature (macro PIXEL_BINNER_ROUND_EN):
//   defined   : output = sat((sum + 2^(k-1)) >> k), k = log2(BIN_X*BIN_Y)
//   undefined : output = sum >> k (floor)
//
// Ports:
//   clk             sole clock
//   s_axis_resetn   asynchronous active-low reset
//   s_axis_tvalid   input pixel valid
//   s_axis_tready   input pixel accepted (combinational on m_axis_tready)
//   s_axis_tdata    input pixel
//   s_axis_tuser    input sideband
//   s_cnt_col       column of the current input pixel
//   s_cnt_row       row of the current input pixel
//   m_axis_tvalid   binned pixel valid
//   m_axis_tready   downstream ready
//   m_axis_tdata    binned pixel
//   m_axis_tuser    tuser of the input pixel that completed the bin
//   m_axis_tlast    high on the last binned pixel of the frame
//   frame_done      one-cycle pulse after the last binned pixel handshakes
// -----------------------------------------------------------------------------
module pixel_binner #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10
) (
  input  logic                         clk,
  input  logic                         s_axis_resetn,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  input  logic [$clog2(IN_COLS)-1:0]   s_cnt_col,
  input  logic [$clog2(IN_ROWS)-1:0]   s_cnt_row,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         frame_done
);

  localparam int BIN_Y  = IN_ROWS / OUT_ROWS;
  localparam int BIN_X  = IN_COLS / OUT_COLS;
  localparam int K      = $clog2(BIN_X * BIN_Y);
  localparam int ACC_W  = PIXEL_BIT_WIDTH + K;
  localparam int COL_W  = $clog2(IN_COLS);
  localparam int ROW_W  = $clog2(IN_ROWS);
  localparam int LOG_BX = $clog2(BIN_X);
  localparam int OX_W   = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

  typedef enum logic [1:0] {
    ST_SYNC,   // waiting for (0,0), everything else is dropped
    ST_RUN,    // binning the frame
    ST_DRAIN,  // last pixel taken, waiting for the final output to leave
    ST_DONE    // frame_done pulse
  } state_e;

  state_e                       state_q, state_d;
  logic [ACC_W-1:0]             h_acc_q, h_acc_d;
  logic                         m_valid_q, m_valid_d;
  logic [PIXEL_BIT_WIDTH-1:0]   m_data_q, m_data_d;
  logic [USER_WIDTH-1:0]        m_user_q, m_user_d;
  logic                         m_last_q, m_last_d;
  logic [ACC_W-1:0]             line_buf_q [OUT_COLS];

  // Coordinates inside the bin (sx, sy) and the output column (ox).
  logic [COL_W-1:0]             sx;
  logic [ROW_W-1:0]             sy;
  logic [OX_W-1:0]              ox;
  logic                         at_origin, at_last;
  logic                         process;   // accepted pixel that feeds the datapath
  logic                         row_end, bin_done, oh;
  logic [ACC_W-1:0]             h_acc_next, v_sum;
  logic [PIXEL_BIT_WIDTH-1:0]   bin_avg;

  // Bins are powers of two, so mod/div reduce to mask/shift.
  assign sx        = s_cnt_col & COL_W'(BIN_X - 1);
  assign sy        = s_cnt_row & ROW_W'(BIN_Y - 1);
  assign ox        = OX_W'(s_cnt_col >> LOG_BX);
  assign at_origin = (s_cnt_row == '0) && (s_cnt_col == '0);
  assign at_last   = (s_cnt_row == ROW_W'(IN_ROWS - 1)) && (s_cnt_col == COL_W'(IN_COLS - 1));
  assign oh        = m_valid_q && m_axis_tready;

  assign row_end   = (sx == COL_W'(BIN_X - 1));
  assign bin_done  = process && row_end && (sy == ROW_W'(BIN_Y - 1));

  assign h_acc_next = (sx == '0) ? ACC_W'(s_axis_tdata) : h_acc_q + ACC_W'(s_axis_tdata);
  // Row 0 of a bin starts a fresh vertical sum, so stale line-buffer data is never added.
  assign v_sum      = h_acc_next + ((sy != '0) ? line_buf_q[ox] : '0);

`ifdef PIXEL_BINNER_ROUND_EN
  localparam logic [ACC_W:0] HALF    = (ACC_W + 1)'((1 << K) >> 1);
  localparam logic [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << PIXEL_BIT_WIDTH) - 1);
  logic [ACC_W:0] rounded, shifted;
  // One extra bit so that adding the half-LSB cannot wrap before saturation.
  assign rounded = {1'b0, v_sum} + HALF;
  assign shifted = rounded >> K;
  assign bin_avg = (shifted > PIX_MAX) ? {PIXEL_BIT_WIDTH{1'b1}}
                                       : shifted[PIXEL_BIT_WIDTH-1:0];
`else
  assign bin_avg = PIXEL_BIT_WIDTH'(v_sum >> K);
`endif

  // Frame-level control.
  // NOTE: every output of an always_comb gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    frame_done    = 1'b0;
    process       = 1'b0;
    unique case (state_q)
      ST_SYNC: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && at_origin) begin
          process = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Accept only when the output register is free or being emptied this cycle.
        s_axis_tready = !m_valid_q || m_axis_tready;
        if (s_axis_tvalid && s_axis_tready) begin
          process = 1'b1;
          if (at_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (oh) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Accumulator and output register next state.
  always_comb begin
    h_acc_d   = h_acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    if (process) h_acc_d = h_acc_next;
    if (oh) m_valid_d = 1'b0;
    // A completing pixel in the same cycle as an output handshake reloads the
    // register with no bubble.
    if (bin_done) begin
      m_valid_d = 1'b1;
      m_data_d  = bin_avg;
      m_user_d  = s_axis_tuser;
      m_last_d  = at_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q   <= ST_SYNC;
      h_acc_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_acc_q   <= h_acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
      m_last_q  <= m_last_d;
    end
  end

  // NOTE: the line buffer is deliberately not reset: each entry is written at
  // sy==0 before it is ever read, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (process && row_end && (sy != ROW_W'(BIN_Y - 1))) begin
      line_buf_q[ox] <= v_sum;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_pixel_binner.sv
// -----------------------------------------------------------------------------
// tb_pixel_binner
//
// Self-checking bench for pixel_binner. A frame is held in plain 2-D arrays; the
// expected output of every bin is computed by summing its block and dividing
// (floor, or rounded and saturated when PIXEL_BINNER_ROUND_EN is defined).
// A negedge monitor collects every output handshake and watches that held
// outputs stay stable while stalled.
// -----------------------------------------------------------------------------
module tb_pixel_binner;

  localparam int PW       = 10;
  localparam int UW       = 2;
  localparam int IN_ROWS  = 20;
  localparam int IN_COLS  = 20;
  localparam int OUT_ROWS = 10;
  localparam int OUT_COLS = 10;
  localparam int BY       = IN_ROWS / OUT_ROWS;
  localparam int BX       = IN_COLS / OUT_COLS;
  localparam int K        = $clog2(BX * BY);
  localparam int COL_W    = $clog2(IN_COLS);
  localparam int ROW_W    = $clog2(IN_ROWS);
  localparam int NOUT     = OUT_ROWS * OUT_COLS;
  localparam int PIX_MAX  = (1 << PW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready;
  logic [PW-1:0]    s_data;
  logic [UW-1:0]    s_user;
  logic [COL_W-1:0] s_col;
  logic [ROW_W-1:0] s_row;
  logic             m_valid, m_ready, m_last, frame_done;
  logic [PW-1:0]    m_data;
  logic [UW-1:0]    m_user;

  always #5 clk = ~clk;

  pixel_binner #(
    .PIXEL_BIT_WIDTH(PW), .USER_WIDTH(UW),
    .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS)
  ) dut (
    .clk           (clk),
    .s_axis_resetn (rst_n),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tuser  (s_user),
    .s_cnt_col     (s_col),
    .s_cnt_row     (s_row),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tuser  (m_user),
    .m_axis_tlast  (m_last),
    .frame_done    (frame_done)
  );

  typedef struct packed {
    logic [PW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } out_t;

  out_t got[$];
  out_t exp_q[$];
  int n_checks = 0;
  int n_fails = 0;
  int fd_count = 0;
  int stall_viol = 0;
  int ready_viol = 0;
  int rdy_mode = 0;
  int gap_pct = 0;
  int cyc = 0;

  logic [PW-1:0] fr_data [IN_ROWS][IN_COLS];
  logic [UW-1:0] fr_user [IN_ROWS][IN_COLS];

  // Output monitor.
  out_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    out_t o;
    if (rst_n) begin
      o.data = m_data;
      o.user = m_user;
      o.last = m_last;
      if (held_v && (!m_valid || o !== held)) stall_viol++;
      if (m_valid && m_ready) got.push_back(o);
      if (frame_done) fd_count++;
      held_v = m_valid && !m_ready;
      held   = o;
    end else begin
      held_v = 1'b0;
    end
  end

  // Downstream ready generator.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 != 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- frame content ----------------
  task automatic fill_ramp();
    for (int r = 0; r < IN_ROWS; r++)
      for (int c = 0; c < IN_COLS; c++) begin
        fr_data[r][c] = PW'(20 * r + c);
        fr_user[r][c] = '0;
      end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < IN_ROWS; r++)
      for (int c = 0; c < IN_COLS; c++) begin
        fr_data[r][c] = PW'(v);
        fr_user[r][c] = '0;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < IN_ROWS; r++)
      for (int c = 0; c < IN_COLS; c++) begin
        fr_data[r][c] = PW'($urandom);
        fr_user[r][c] = UW'($urandom);
      end
  endtask

  // Reference: expected outputs for the first n_out_rows bin rows of the frame.
  task automatic model_frame(input int n_out_rows);
    for (int orow = 0; orow < n_out_rows; orow++)
      for (int oc = 0; oc < OUT_COLS; oc++) begin
        int sum;
        int avg;
        out_t o;
        sum = 0;
        for (int dy = 0; dy < BY; dy++)
          for (int dx = 0; dx < BX; dx++)
            sum += int'(fr_data[orow * BY + dy][oc * BX + dx]);
`ifdef PIXEL_BINNER_ROUND_EN
        avg = (sum + (BX * BY) / 2) / (BX * BY);
        if (avg > PIX_MAX) avg = PIX_MAX;
`else
        avg = sum / (BX * BY);
`endif
        o.data = PW'(avg);
        o.user = fr_user[orow * BY + BY - 1][oc * BX + BX - 1];
        o.last = (orow == OUT_ROWS - 1) && (oc == OUT_COLS - 1);
        exp_q.push_back(o);
      end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic send_pixel(input int r, input int c);
    int budget;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_row   = ROW_W'(r);
    s_col   = COL_W'(c);
    s_data  = fr_data[r][c];
    s_user  = fr_user[r][c];
    budget  = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      if (!(m_valid && !m_ready)) ready_viol++;
      budget++;
      if (budget > 200) begin
        n_checks++;
        n_fails++;
        $display("FAIL send_timeout: pixel (%0d,%0d) not accepted after %0d cycles, expected acceptance", r, c, budget);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int r0, input int c0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = (r == r0) ? c0 : 0; c < IN_COLS; c++)
        send_pixel(r, c);
  endtask

  task automatic start_test(input int mode, input int gap);
    rdy_mode   = mode;
    gap_pct    = gap;
    got.delete();
    exp_q.delete();
    fd_count   = 0;
    stall_viol = 0;
    ready_viol = 0;
  endtask

  task automatic wait_frame_done(input string name);
    int t;
    t = 0;
    while (fd_count < 1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (fd_count !== 1) begin
      n_fails++;
      $display("FAIL %s_frame_done: pulse cycles=%0d expected 1", name, fd_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_outputs(input string name);
    n_checks++;
    if (got.size() !== exp_q.size()) begin
      n_fails++;
      $display("FAIL %s_count: got %0d outputs expected %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_fails++;
        $display("FAIL %s_out[%0d]: got data=%0d user=%0d last=%0b expected data=%0d user=%0d last=%0b",
                 name, i, got[i].data, got[i].user, got[i].last,
                 exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
    end
    n_checks++;
    if (stall_viol !== 0) begin
      n_fails++;
      $display("FAIL %s_stall_stable: %0d held-output changes expected 0", name, stall_viol);
    end
    n_checks++;
    if (ready_viol !== 0) begin
      n_fails++;
      $display("FAIL %s_tready: %0d unexplained tready drops expected 0", name, ready_viol);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (m_valid !== 1'b0) begin n_fails++; $display("FAIL reset_tvalid: got %b expected 0", m_valid); end
    n_checks++;
    if (m_data !== '0) begin n_fails++; $display("FAIL reset_tdata: got %0d expected 0", m_data); end
    n_checks++;
    if (m_user !== '0) begin n_fails++; $display("FAIL reset_tuser: got %0d expected 0", m_user); end
    n_checks++;
    if (m_last !== 1'b0) begin n_fails++; $display("FAIL reset_tlast: got %b expected 0", m_last); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++;
    if (s_ready !== 1'b1) begin n_fails++; $display("FAIL reset_tready: got %b expected 1", s_ready); end
  endtask

  task automatic test_ramp();
    int e00, e99;
`ifdef PIXEL_BINNER_ROUND_EN
    e00 = 11; e99 = 389;
`else
    e00 = 10; e99 = 388;
`endif
    start_test(0, 0);
    fill_ramp();
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("ramp");
    compare_outputs("ramp");
    n_checks++;
    if (got.size() < NOUT || int'(got[0].data) !== e00) begin
      n_fails++;
      $display("FAIL ramp_first: got %0d expected %0d", (got.size() > 0) ? int'(got[0].data) : -1, e00);
    end
    n_checks++;
    if (got.size() < NOUT || int'(got[NOUT-1].data) !== e99) begin
      n_fails++;
      $display("FAIL ramp_last: got %0d expected %0d", (got.size() >= NOUT) ? int'(got[NOUT-1].data) : -1, e99);
    end
  endtask

  task automatic test_saturate();
    start_test(0, 0);
    fill_const(PIX_MAX);
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("saturate");
    compare_outputs("saturate");
  endtask

  task automatic test_backpressure();
    start_test(1, 0);
    fill_ramp();
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("backpressure");
    compare_outputs("backpressure");
  endtask

  task automatic test_sync();
    start_test(0, 0);
    fill_ramp();
    send_range(3, 5, IN_ROWS - 1);  // no (0,0) yet: all dropped
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("sync");
    compare_outputs("sync");
  endtask

  task automatic test_restart();
    start_test(0, 0);
    fill_random();
    model_frame(4 / BY);            // rows 0..3 complete their bins
    send_range(0, 0, 4);            // row 4 leaves a bin in progress
    fill_random();
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("restart");
    compare_outputs("restart");
  endtask

  task automatic test_tuser();
    start_test(0, 0);
    fill_ramp();
    fr_user[1][1] = 2'b10;
    for (int c = 2; c < IN_COLS; c++) fr_user[1][c] = UW'($urandom);
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("tuser");
    compare_outputs("tuser");
    n_checks++;
    if (got.size() == 0 || got[0].user !== 2'b10) begin
      n_fails++;
      $display("FAIL tuser_first: got %0d expected 2", (got.size() > 0) ? int'(got[0].user) : -1);
    end
  endtask

  task automatic test_random();
    start_test(2, 30);
    fill_random();
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("random");
    compare_outputs("random");
  endtask

  task automatic test_reset_mid();
    bit stop;
    start_test(0, 0);
    fill_ramp();
    stop = 1'b0;
    for (int r = 0; r < IN_ROWS && !stop; r++)
      for (int c = 0; c < IN_COLS && !stop; c++) begin
        send_pixel(r, c);
        if (got.size() >= 37) stop = 1'b1;
      end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fails++; $display("FAIL midreset_tvalid: got %b expected 0", m_valid); end
    n_checks++;
    if (m_data !== '0) begin n_fails++; $display("FAIL midreset_tdata: got %0d expected 0", m_data); end
    n_checks++;
    if (m_user !== '0 || m_last !== 1'b0 || frame_done !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_side: got user=%0d last=%b done=%b expected 0 0 0", m_user, m_last, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_test(0, 0);
    model_frame(OUT_ROWS);
    send_range(0, 0, IN_ROWS - 1);
    wait_frame_done("midreset");
    compare_outputs("midreset");
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_user  = '0;
    s_row   = '0;
    s_col   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_saturate();
    test_backpressure();
    test_sync();
    test_restart();
    test_tuser();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pixel_binner.md
# pixel_binner

Downstream neighbour of the burst-to-pixel sequentializer. Consumes its single-pixel AXI-Stream output, together with its row/column counters, and bins each IN_ROWS×IN_COLS frame down to OUT_ROWS×OUT_COLS. Each output pixel is the average of one BIN_Y×BIN_X input block. Output is a single-pixel AXI-Stream in raster order with an end-of-frame marker, ready for the next processing stage.

## Interface
- PIXEL_BIT_WIDTH, 10, bits per pixel (input and output)
- USER_WIDTH, 2, sideband width carried with each pixel
- IN_ROWS, 20, input frame rows; must equal OUT_ROWS·BIN_Y
- IN_COLS, 20, input frame columns; must equal OUT_COLS·BIN_X
- OUT_ROWS, 10, output frame rows
- OUT_COLS, 10, output frame columns
- Derived: BIN_Y=IN_ROWS/OUT_ROWS and BIN_X=IN_COLS/OUT_COLS, both powers of two ≥1; ACC_W=PIXEL_BIT_WIDTH+log2(BIN_X·BIN_Y)

Ports:
- clk  in  1  sole clock
- s_axis_resetn  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tready  out  1  input pixel accepted
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel
- s_axis_tuser  in  USER_WIDTH  input sideband
- s_cnt_col  in  $clog2(IN_COLS)  column of the current input pixel
- s_cnt_row  in  $clog2(IN_ROWS)  row of the current input pixel
- m_axis_tvalid  out  1  binned pixel valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  PIXEL_BIT_WIDTH  binned pixel
- m_axis_tuser  out  USER_WIDTH  tuser of the input pixel that completed the bin
- m_axis_tlast  out  1  high on the last binned pixel of the frame
- frame_done  out  1  one-cycle pulse after the last binned pixel handshakes

## Operation
- Input handshake (IH) = s_axis_tvalid && s_axis_tready. Output handshake (OH) = m_axis_tvalid && m_axis_tready.
- Coordinates are taken only on IH:
  - sx = s_cnt_col mod BIN_X, sy = s_cnt_row mod BIN_Y
  - ox = s_cnt_col / BIN_X, oy = s_cnt_row / BIN_Y
- Horizontal accumulator h_acc (ACC_W bits):
  - sx==0 loads the pixel.
  - Otherwise the pixel is added to h_acc.
- Line buffer of OUT_COLS entries, ACC_W bits each, holding vertical partial sums. On IH with sx==BIN_X-1, let t = h_acc_next, plus line_buf[ox] when sy≠0:
  - If sy<BIN_Y-1, write t to line_buf[ox].
  - Else the bin is complete: the output register takes t >> log2(BIN_X·BIN_Y), and m_axis_tvalid sets.
- The line buffer has no reset. Entries are always overwritten at sy==0 before they are read.
- FSM states:
  - SYNC: s_axis_tready=1; pixels are dropped. IH with (row,col)=(0,0) → RUN, and that pixel is processed.
  - RUN: s_axis_tready = !m_axis_tvalid || m_axis_tready. IH on (IN_ROWS-1, IN_COLS-1) → DRAIN.
  - DRAIN: s_axis_tready=0. OH → DONE.
  - DONE: frame_done=1 for one cycle → SYNC.
- In RUN, an IH at (0,0) restarts accumulation. The bin in progress is discarded; no error is flagged.
- m_axis_tlast is registered with the data: set when the completing pixel is (IN_ROWS-1, IN_COLS-1).
- m_axis_tdata, m_axis_tuser and m_axis_tlast hold stable while m_axis_tvalid && !m_axis_tready.

## Timing
- Reset values:
  - State = SYNC.
  - m_axis_tvalid, m_axis_tlast, frame_done, m_axis_tdata, m_axis_tuser = 0.
  - h_acc = 0.
  - s_axis_tready = 1 (SYNC).
- Latency: m_axis_tvalid rises on the clock edge following the completing IH.
- Throughput: one IH per cycle while the downstream keeps m_axis_tready high.
- Back-pressure: s_axis_tready depends combinationally on m_axis_tready.
- Simultaneous OH and completing IH in the same cycle: the new result is loaded and m_axis_tvalid stays 1 with no bubble.
- frame_done is asserted the cycle after the final OH.
- Reset mid-frame: all registers clear asynchronously, and outputs drop immediately. The partial frame is lost; the block resynchronises at the next (0,0).
- Arithmetic: unsigned throughout. Sums never overflow ACC_W; the rounding adder is ACC_W+1 bits.

## Configuration
- PIXEL_BINNER_ROUND_EN defined: output = (sum + 2^(k-1)) >> k, with k = log2(BIN_X·BIN_Y), saturated to 2^PIXEL_BIT_WIDTH-1. When k=0, output = sum.
- PIXEL_BINNER_ROUND_EN undefined: output = sum >> k (floor).

## Test plan
- Defaults, ramp input pixel(r,c) = 20r+c, m_axis_tready=1 → 100 outputs with out(or,oc) = 40·or+2·oc+10 (floor) or +11 (ROUND_EN). out(0,0) = 10/11, out(9,9) = 388/389. tlast only on the 100th output; frame_done pulses once.
- All pixels 1023 → every output is 1023 in both modes, with no wrap.
- Ramp input with m_axis_tready toggled 1-of-3 → identical output sequence. Data is stable under stall, and s_axis_tready drops only while the output is held.
- Stream starting at (3,5) before a (0,0) → pixels are dropped until (0,0); the following full frame matches the first case exactly.
- Assert s_axis_resetn low at output 37 → all outputs are 0 immediately. After release, a fresh ramp frame gives the full 100 correct outputs.
- tuser=2'b10 only on input (1,1) → first output carries tuser=2'b10; later outputs carry the tuser of their completing pixel.
